// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Builds 32-bit MIPS instruction words from a mnemonic ID plus operand fields
// and streams them, with sequential word addresses, to the instruction-memory
// loader. The encoder is the inverse of the CPU's main control decoder. It can
// optionally insert a NOP word after every branch or jump to fill the delay
// slot.
//
// Parameters
//   AW          word-address width; the address counter wraps at 2^AW
//   DELAY_SLOT  1 = emit a NOP word (0x00000000) after every branch/jump word
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   clr_i        synchronous clear (counter, err_o, pending words)
//   in_valid_i   request valid
//   in_ready_o   encoder can accept a request this cycle
//   mnem_i       mnemonic ID (0..12 supported)
//   rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, target_i   operand fields
//   out_valid_o  instr_o/addr_o valid
//   out_ready_i  sink accepts the word
//   instr_o      encoded instruction word
//   addr_o       word address of instr_o
//   err_o        sticky flag: an unsupported mnemonic was accepted
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int unsigned AW         = 8,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [3:0]    mnem_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    shamt_i,
    input  logic [5:0]    funct_i,
    input  logic [15:0]   imm_i,
    input  logic [25:0]   target_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   instr_o,
    output logic [AW-1:0] addr_o,
    output logic          err_o
);

    // state    | meaning
    // ---------+------------------------------------------------------------
    // ST_EMPTY | no word held; ready for a request
    // ST_WORD  | encoded word presented on instr_o/addr_o
    // ST_NOP   | delay-slot NOP presented after a branch/jump word
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WORD  = 2'd1,
        ST_NOP   = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LI    = 6'b001111;

    state_t          state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [AW-1:0]   addr_q,  addr_d;
    logic            err_q,   err_d;
    logic            bj_q,    bj_d;     // held word is a branch/jump

    logic [31:0]     enc_word;
    logic            enc_ok;
    logic            enc_bj;
    logic            accept;
    logic            out_fire;

    // Mnemonic to instruction word. bltz carries no rt and li no rs, so those
    // fields are forced to zero regardless of what the requester drives.
    always_comb begin
        enc_word = 32'd0;
        enc_ok   = 1'b1;
        enc_bj   = 1'b0;
        case (mnem_i)
            4'd0:  enc_word = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
            4'd1:  begin enc_word = {OP_BEQ,  rs_i, rt_i, imm_i}; enc_bj = 1'b1; end
            4'd2:  begin enc_word = {OP_BNE,  rs_i, rt_i, imm_i}; enc_bj = 1'b1; end
            4'd3:  begin enc_word = {OP_BLE,  rs_i, rt_i, imm_i}; enc_bj = 1'b1; end
            4'd4:  begin enc_word = {OP_BLTZ, rs_i, 5'd0, imm_i}; enc_bj = 1'b1; end
            4'd5:  enc_word = {OP_ADDI,  rs_i, rt_i, imm_i};
            4'd6:  enc_word = {OP_SLTIU, rs_i, rt_i, imm_i};
            4'd7:  enc_word = {OP_ORI,   rs_i, rt_i, imm_i};
            4'd8:  enc_word = {OP_LW,    rs_i, rt_i, imm_i};
            4'd9:  enc_word = {OP_SW,    rs_i, rt_i, imm_i};
            4'd10: begin enc_word = {OP_J,   target_i}; enc_bj = 1'b1; end
            4'd11: begin enc_word = {OP_JAL, target_i}; enc_bj = 1'b1; end
            4'd12: enc_word = {OP_LI, 5'd0, rt_i, imm_i};
            default: enc_ok = 1'b0;
        endcase
    end

    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_fire    = out_valid_o & out_ready_i;

    // A branch/jump word with delay slots enabled must be followed by the NOP,
    // so no new request may be taken in the cycle that word leaves.
    always_comb begin
        in_ready_o = 1'b0;
        if (!clr_i) begin
            case (state_q)
                ST_EMPTY: in_ready_o = 1'b1;
                ST_WORD:  in_ready_o = out_ready_i & ~(bj_q & DELAY_SLOT);
                ST_NOP:   in_ready_o = out_ready_i;
                default:  in_ready_o = 1'b0;
            endcase
        end
    end

    assign accept = in_valid_i & in_ready_o;

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        bj_d    = bj_q;

        if (clr_i) begin
            state_d = ST_EMPTY;
            instr_d = 32'd0;
            addr_d  = '0;
            err_d   = 1'b0;
            bj_d    = 1'b0;
        end else begin
            // Unsupported IDs are consumed but produce no word.
            if (accept && !enc_ok) begin
                err_d = 1'b1;
            end

            if (out_fire) begin
                addr_d = addr_q + AW'(1);
            end

            case (state_q)
                ST_EMPTY: begin
                    if (accept && enc_ok) begin
                        state_d = ST_WORD;
                        instr_d = enc_word;
                        bj_d    = enc_bj;
                    end
                end
                ST_WORD: begin
                    if (out_fire) begin
                        if (bj_q && DELAY_SLOT) begin
                            state_d = ST_NOP;
                            instr_d = 32'd0;
                            bj_d    = 1'b0;
                        end else if (accept && enc_ok) begin
                            state_d = ST_WORD;
                            instr_d = enc_word;
                            bj_d    = enc_bj;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
                ST_NOP: begin
                    if (out_fire) begin
                        if (accept && enc_ok) begin
                            state_d = ST_WORD;
                            instr_d = enc_word;
                            bj_d    = enc_bj;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            instr_q <= 32'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            bj_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            bj_q    <= bj_d;
        end
    end

    assign instr_o = instr_q;
    assign addr_o  = addr_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder. Three instances share one stimulus bus:
//   dut0  AW=8, DELAY_SLOT=0  (encoding, streaming, stall, error/clear)
//   dut1  AW=8, DELAY_SLOT=1  (delay-slot NOP insertion)
//   dut2  AW=2, DELAY_SLOT=0  (address wrap, reset mid-stall)
// Inputs change on the falling edge; outputs are checked on the falling edge
// (or #1 after it for the combinational in_ready_o).
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [3:0]  mnem;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_ready;

    logic        rdy0, ov0, er0;
    logic [31:0] ins0;
    logic [7:0]  ad0;
    logic        rdy1, ov1, er1;
    logic [31:0] ins1;
    logic [7:0]  ad1;
    logic        rdy2, ov2, er2;
    logic [31:0] ins2;
    logic [1:0]  ad2;

    int n_tot;
    int n_bad;

    typedef struct {
        logic [3:0]  m;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [25:0] tg;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[9];

    instr_encoder #(.AW(8), .DELAY_SLOT(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(rdy0),
        .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .out_valid_o(ov0), .out_ready_i(out_ready),
        .instr_o(ins0), .addr_o(ad0), .err_o(er0)
    );

    instr_encoder #(.AW(8), .DELAY_SLOT(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(rdy1),
        .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .out_valid_o(ov1), .out_ready_i(out_ready),
        .instr_o(ins1), .addr_o(ad1), .err_o(er1)
    );

    instr_encoder #(.AW(2), .DELAY_SLOT(1'b0)) dut2 (
        .clk_i(clk), .rst_i(rst_n), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(rdy2),
        .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target),
        .out_valid_o(ov2), .out_ready_i(out_ready),
        .instr_o(ins2), .addr_o(ad2), .err_o(er2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] im, input logic [25:0] tg);
        mnem   = m;
        rs     = s;
        rt     = t;
        rd     = d;
        shamt  = sh;
        funct  = fn;
        imm    = im;
        target = tg;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        n_tot = 0;
        n_bad = 0;
        set_req(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

        //          m      rs     rt     rd     sh    fn      imm        target        expected
        vt[0] = '{4'd0,  5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'h0000, 26'h0,       32'h01095020};
        vt[1] = '{4'd8,  5'd29, 5'd2,  5'd0,  5'd0, 6'h00, 16'h0004, 26'h0,       32'h8FA20004};
        vt[2] = '{4'd6,  5'd1,  5'd2,  5'd0,  5'd0, 6'h00, 16'h8000, 26'h0,       32'h24228000};
        vt[3] = '{4'd3,  5'd31, 5'd0,  5'd0,  5'd0, 6'h00, 16'h0003, 26'h0,       32'h1BE00003};
        vt[4] = '{4'd2,  5'd2,  5'd3,  5'd0,  5'd0, 6'h00, 16'h0100, 26'h0,       32'h14430100};
        vt[5] = '{4'd11, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};
        vt[6] = '{4'd0,  5'd0,  5'd5,  5'd6,  5'd4, 6'h00, 16'h0000, 26'h0,       32'h00053100};
        vt[7] = '{4'd4,  5'd7,  5'd31, 5'd0,  5'd0, 6'h00, 16'h0010, 26'h0,       32'h04E00010};
        vt[8] = '{4'd12, 5'd5,  5'd3,  5'd0,  5'd0, 6'h00, 16'hABCD, 26'h0,       32'h3C03ABCD};

        // reset state and first addi
        do_reset();
        chk("rst_valid", 32'(ov0), 32'd0);
        chk("rst_instr", ins0, 32'd0);
        chk("rst_addr",  32'(ad0), 32'd0);
        chk("rst_err",   32'(er0), 32'd0);
        chk("rst_ready", 32'(rdy0), 32'd1);
        set_req(4'd5, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("addi_valid", 32'(ov0), 32'd1);
        chk("addi_instr", ins0, 32'h21090005);
        chk("addi_addr",  32'(ad0), 32'd0);
        @(negedge clk);
        chk("addi_done_valid", 32'(ov0), 32'd0);
        chk("addi_done_addr",  32'(ad0), 32'd1);

        // back-to-back stream through the whole opcode table
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_req(vt[i].m, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn, vt[i].im, vt[i].tg);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("tbl%0d_instr", i), ins0, vt[i].exp);
            chk($sformatf("tbl%0d_addr", i),  32'(ad0), 32'(i));
            chk($sformatf("tbl%0d_valid", i), 32'(ov0), 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tbl_end_valid", 32'(ov0), 32'd0);
        chk("tbl_end_addr",  32'(ad0), 32'd9);

        // stall with a second request waiting
        do_reset();
        set_req(4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("stall_first", ins0, 32'h34641234);
        set_req(4'd9, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h0008, 26'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), 32'(rdy0), 32'd0);
            @(negedge clk);
            chk($sformatf("stall%0d_instr", k), ins0, 32'h34641234);
            chk($sformatf("stall%0d_addr", k),  32'(ad0), 32'd0);
            chk($sformatf("stall%0d_valid", k), 32'(ov0), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("release_instr", ins0, 32'h ACA60008);
        chk("release_addr",  32'(ad0), 32'd1);
        @(negedge clk);
        chk("release_done_valid", 32'(ov0), 32'd0);
        chk("release_done_addr",  32'(ad0), 32'd2);

        // delay-slot NOP insertion (dut1)
        do_reset();
        set_req(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        chk("ds_beq_instr", ins1, 32'h1022FFFF);
        chk("ds_beq_addr",  32'(ad1), 32'd0);
        set_req(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10);
        #1;
        chk("ds_beq_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("ds_nop1_instr", ins1, 32'd0);
        chk("ds_nop1_addr",  32'(ad1), 32'd1);
        chk("ds_nop1_valid", 32'(ov1), 32'd1);
        out_ready = 1'b0;
        #1;
        chk("ds_nop1_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("ds_nop1_hold_instr", ins1, 32'd0);
        chk("ds_nop1_hold_addr",  32'(ad1), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ds_j_instr", ins1, 32'h08000010);
        chk("ds_j_addr",  32'(ad1), 32'd2);
        #1;
        chk("ds_j_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("ds_nop2_instr", ins1, 32'd0);
        chk("ds_nop2_addr",  32'(ad1), 32'd3);
        chk("ds_nop2_valid", 32'(ov1), 32'd1);
        @(negedge clk);
        chk("ds_end_valid", 32'(ov1), 32'd0);
        chk("ds_end_addr",  32'(ad1), 32'd4);

        // unsupported mnemonic, sticky error, synchronous clear
        do_reset();
        set_req(4'd14, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1111, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bad_valid", 32'(ov0), 32'd0);
        chk("bad_err",   32'(er0), 32'd1);
        chk("bad_addr",  32'(ad0), 32'd0);
        @(negedge clk);
        chk("bad_err_sticky", 32'(er0), 32'd1);
        set_req(4'd5, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0007, 26'd0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("after_bad_instr", ins0, 32'h21090007);
        chk("after_bad_addr",  32'(ad0), 32'd0);
        @(negedge clk);
        chk("after_bad_addr2", 32'(ad0), 32'd1);
        chk("after_bad_err",   32'(er0), 32'd1);
        clr = 1'b1;
        set_req(4'd12, 5'd0, 5'd3, 5'd0, 5'd0, 6'd0, 16'h5555, 26'd0);
        in_valid = 1'b1;
        #1;
        chk("clr_ready", 32'(rdy0), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_err",   32'(er0), 32'd0);
        chk("clr_addr",  32'(ad0), 32'd0);
        chk("clr_valid", 32'(ov0), 32'd0);

        // AW=2 wrap, then reset while stalled (dut2)
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req(4'd5, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
            in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("wrap%0d_addr", i),  32'(ad2), 32'(i % 4));
            chk($sformatf("wrap%0d_instr", i), ins2, 32'h21090000 | 32'(i));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("wrap_hold_valid", 32'(ov2), 32'd1);
        chk("wrap_hold_addr",  32'(ad2), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov2), 32'd0);
        chk("midrst_instr", ins2, 32'd0);
        chk("midrst_addr",  32'(ad2), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 32'(ov2), 32'd0);
        chk("postrst_ready", 32'(rdy2), 32'd1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
